br_lite_inject_arbiter: RTL and testbench

Per-PE injection controller for the BrLite broadcast NoC. It shares one router local input port (flit/req/ack plus busy) among REQ_CNT local requesters using round-robin. For each flit it stamps the local source address and a wrapping 5-bit packet id, then runs the router's four-phase req/ack handshake. It sits between the PE-side service queues and the BrLiteRouter local port.

---
 rtl/br_lite_pkg.sv | 29 ++
 rtl/br_lite_rr_arbiter.sv | 35 +++
 rtl/br_lite_inject_arbiter.sv | 141 ++++++++++++++
 tb/tb_br_lite_inject_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_lite_pkg.sv
// Shared BrLite NoC types: flit layout, service codes and field widths.
package br_lite_pkg;

  localparam int BR_ID_W      = 5;
  localparam int BR_XY_W      = 16;
  localparam int BR_PAYLOAD_W = 32;
  localparam int BR_SVC_W     = 2;

  typedef enum logic [BR_SVC_W-1:0] {
    BR_SVC_ALL = 2'd0,
    BR_SVC_TGT = 2'd1,
    BR_SVC_CLR = 2'd2,
    BR_SVC_MON = 2'd3
  } br_svc_t;

  typedef struct packed {
    logic [BR_XY_W-1:0]      source;
    logic [BR_XY_W-1:0]      target;
    logic [BR_PAYLOAD_W-1:0] payload;
    br_svc_t                 service;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

  // Packet ids wrap naturally at 2**BR_ID_W.
  function automatic logic [BR_ID_W-1:0] br_next_id(input logic [BR_ID_W-1:0] id);
    return id + BR_ID_W'(1);
  endfunction

endpackage

// File: rtl/br_lite_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after ptr_i, wrapping.
module br_lite_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam int SW = IW + 1;
  localparam logic [SW-1:0] N_V = SW'(N);

  logic [SW-1:0] w_sum;

  // Scan ptr+1 .. ptr+N (mod N); the first valid candidate wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_sum   = '0;
    for (int i = 1; i <= N; i++) begin
      w_sum = {1'b0, ptr_i} + SW'(i);
      if (w_sum >= N_V) w_sum = w_sum - N_V;
      if (!any_o && valid_i[w_sum[IW-1:0]]) begin
        any_o = 1'b1;
        idx_o = w_sum[IW-1:0];
      end
    end
    grant_o[idx_o] = any_o;
  end

endmodule

// File: rtl/br_lite_inject_arbiter.sv
// Per-PE injection controller: round-robin shares the router local port among
// REQ_CNT requesters, stamps source/id on each flit and runs the router's
// four-phase req/ack handshake.
//
// Requester side: a flit moves from requester r on a cycle where
// req_valid_i[r] & req_ready_o[r]; ready is one-hot, only ever raised in IDLE
// with busy_i low, and valid may be dropped at any time before the grant.
module br_lite_inject_arbiter
  import br_lite_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int STALL_W = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [BR_XY_W-1:0]              local_xy_i,
  input  logic [REQ_CNT-1:0]              req_valid_i,
  output logic [REQ_CNT-1:0]              req_ready_o,
  input  logic [REQ_CNT*BR_XY_W-1:0]      req_target_i,
  input  logic [REQ_CNT*BR_PAYLOAD_W-1:0] req_payload_i,
  input  logic [REQ_CNT*BR_SVC_W-1:0]     req_service_i,
  output br_data_t                        flit_o,
  output logic                            req_o,
  input  logic                            ack_i,
  input  logic                            busy_i,
  output logic [REQ_CNT-1:0]              done_o,
  output logic [BR_ID_W-1:0]              done_id_o,
  output logic [STALL_W-1:0]              stall_cnt_o,
  output logic [1:0]                      state_dbg_o
);

  localparam int IW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_owner;
  logic [BR_ID_W-1:0]      r_id_cnt;
  br_data_t                r_flit;
  logic [REQ_CNT-1:0]      r_done;
  logic [BR_ID_W-1:0]      r_done_id;
  logic [STALL_W-1:0]      r_stall_cnt;

  logic [REQ_CNT-1:0]      w_grant;
  logic [IW-1:0]           w_idx;
  logic                    w_any;
  logic                    w_grant_fire;
  logic                    w_stall;
  logic [BR_XY_W-1:0]      w_sel_target;
  logic [BR_PAYLOAD_W-1:0] w_sel_payload;
  br_svc_t                 w_sel_service;

  br_lite_rr_arbiter #(.N(REQ_CNT)) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (r_ptr),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .any_o   (w_any)
  );

  assign w_grant_fire = (r_state == ST_IDLE) && w_any && !busy_i;
  assign w_stall      = (r_state == ST_IDLE) && (|req_valid_i) && busy_i;

  // Select the winning requester's target/payload/service.
  always_comb begin
    w_sel_target  = '0;
    w_sel_payload = '0;
    w_sel_service = BR_SVC_ALL;
    for (int r = 0; r < REQ_CNT; r++) begin
      if (w_idx == IW'(r)) begin
        w_sel_target  = req_target_i[r*BR_XY_W +: BR_XY_W];
        w_sel_payload = req_payload_i[r*BR_PAYLOAD_W +: BR_PAYLOAD_W];
        w_sel_service = br_svc_t'(req_service_i[r*BR_SVC_W +: BR_SVC_W]);
      end
    end
  end

  // Next-state logic for the injection handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant_fire) w_state_nxt = ST_REQ;
      ST_REQ:     if (ack_i)        w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (!ack_i)       w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Flit capture, id/pointer update, done pulse and busy-stall counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr       <= IW'(REQ_CNT - 1);
      r_owner     <= '0;
      r_id_cnt    <= '0;
      r_flit      <= '0;
      r_done      <= '0;
      r_done_id   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_done <= '0;
      if (w_grant_fire) begin
        r_flit.source  <= local_xy_i;
        r_flit.target  <= w_sel_target;
        r_flit.payload <= w_sel_payload;
        r_flit.service <= w_sel_service;
        r_flit.id      <= r_id_cnt;
        r_id_cnt       <= br_next_id(r_id_cnt);
        r_ptr          <= w_idx;
        r_owner        <= w_idx;
      end
      if ((r_state == ST_REQ) && ack_i) begin
        r_done[r_owner] <= 1'b1;
        r_done_id       <= r_flit.id;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  assign req_ready_o = w_grant_fire ? w_grant : '0;
  assign req_o       = (r_state == ST_REQ);
  assign flit_o      = r_flit;
  assign done_o      = r_done;
  assign done_id_o   = r_done_id;
  assign stall_cnt_o = r_stall_cnt;
  assign state_dbg_o = r_state;

endmodule

// File: tb/tb_br_lite_inject_arbiter.sv
// Bench for br_lite_inject_arbiter: bench-side router model, round-robin model
// and an expected-completion queue checked against done_o/done_id_o.
module tb_br_lite_inject_arbiter;
  import br_lite_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0]        local_xy;
  logic [N-1:0]       valid;
  logic [N-1:0]       ready;
  logic [N-1:0][15:0] tgt;
  logic [N-1:0][31:0] pay;
  logic [N-1:0][1:0]  svc;
  br_data_t           flit;
  logic               req;
  logic               ack;
  logic               busy;
  logic [N-1:0]       done;
  logic [4:0]         done_id;
  logic [15:0]        stall;
  logic [1:0]         st;

  br_lite_inject_arbiter #(.REQ_CNT(N), .STALL_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .local_xy_i    (local_xy),
    .req_valid_i   (valid),
    .req_ready_o   (ready),
    .req_target_i  (tgt),
    .req_payload_i (pay),
    .req_service_i (svc),
    .flit_o        (flit),
    .req_o         (req),
    .ack_i         (ack),
    .busy_i        (busy),
    .done_o        (done),
    .done_id_o     (done_id),
    .stall_cnt_o   (stall),
    .state_dbg_o   (st)
  );

  // ---------------- bookkeeping / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int g_cyc = 0;
  int m_ptr;
  int m_id;
  int m_stall;
  logic [8:0] exp_q[$];  // {owner[3:0], id[4:0]}

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    valid = '0;
    ack   = 1'b0;
    busy  = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
    m_ptr   = N - 1;
    m_id    = 0;
    m_stall = 0;
    exp_q.delete();
  endtask

  function automatic int model_pick(input logic [N-1:0] mask);
    for (int i = 1; i <= N; i++) begin
      if (mask[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return 0;
  endfunction

  // One full transfer with the bench acting as router. Starts in IDLE, ends in IDLE.
  task automatic do_transfer(input logic [N-1:0] mask, input int ack_delay,
                             input int ack_hold, input logic busy_mid,
                             output int id_seen, output int g_seen);
    int g;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_done;
    logic [8:0] e;
    br_data_t exp_f;
    valid = mask;
    busy  = 1'b0;
    #1;
    g = model_pick(mask);
    exp_ready = N'(1 << g);
    g_seen = -1;
    for (int b = 0; b < N; b++) if (ready[b]) g_seen = b;
    n_cmp++;
    if (ready !== exp_ready) begin
      n_err++;
      $display("FAIL grant: ready=%b want %b (cyc %0d)", ready, exp_ready, cyc);
    end
    exp_q.push_back({4'(g), 5'(m_id)});
    g_cyc = cyc;
    tick();
    exp_f.source  = local_xy;
    exp_f.target  = tgt[g];
    exp_f.payload = pay[g];
    exp_f.service = br_svc_t'(svc[g]);
    exp_f.id      = 5'(m_id);
    id_seen = int'(flit.id);
    n_cmp++;
    if (flit !== exp_f) begin
      n_err++;
      $display("FAIL flit: got %h want %h", flit, exp_f);
    end
    m_ptr = g;
    m_id  = (m_id + 1) % 32;
    for (int k = 0; k < ack_delay; k++) begin
      busy = busy_mid;
      #1;
      n_cmp++;
      if (req !== 1'b1 || ready !== '0 || done !== '0) begin
        n_err++;
        $display("FAIL req_phase: req=%b ready=%b done=%b want 1/0/0", req, ready, done);
      end
      if (k == ack_delay - 1) ack = 1'b1;
      tick();
    end
    // first RELEASE cycle
    busy = 1'b0;
    if (ack_hold == 0) ack = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_queue: got empty queue want 1 entry");
    end else begin
      e = exp_q.pop_front();
      exp_done = N'(1 << e[8:5]);
      n_cmp++;
      if (req !== 1'b0 || done !== exp_done || done_id !== e[4:0]) begin
        n_err++;
        $display("FAIL done: req=%b done=%b id=%0d want 0/%b/%0d", req, done, done_id, exp_done, e[4:0]);
      end
    end
    for (int h = 0; h < ack_hold; h++) begin
      tick();
      if (h == ack_hold - 1) ack = 1'b0;
      #1;
      n_cmp++;
      if (st !== 2'd2 || done !== '0 || ready !== '0 || req !== 1'b0) begin
        n_err++;
        $display("FAIL release_hold: st=%0d done=%b ready=%b req=%b want 2/0/0/0", st, done, ready, req);
      end
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++;
    if (req !== 1'b0 || ready !== '0 || done !== '0 || done_id !== '0 || st !== 2'd0) begin
      n_err++;
      $display("FAIL reset_ctrl: req=%b ready=%b done=%b id=%0d st=%0d want all 0", req, ready, done, done_id, st);
    end
    n_cmp++;
    if (flit !== '0 || stall !== '0) begin
      n_err++;
      $display("FAIL reset_data: flit=%h stall=%0d want 0/0", flit, stall);
    end
    valid = 4'b1111;
    #1;
    n_cmp++;
    if (ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_priority: ready=%b want 0001", ready);
    end
    valid = '0;
  endtask

  task automatic test_single();
    int id_s, g_s;
    local_xy = 16'h0102;
    tgt[2] = 16'h0300;
    pay[2] = 32'h0000_00AB;
    svc[2] = BR_SVC_TGT;
    do_transfer(4'b0100, 2, 0, 1'b0, id_s, g_s);
    n_cmp++;
    if (id_s !== 0 || g_s !== 2) begin
      n_err++;
      $display("FAIL single: id=%0d grant=%0d want 0/2", id_s, g_s);
    end
    valid = '0;
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int id_s, g_s, prev;
    apply_reset();
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      do_transfer(4'b1111, 1, 0, 1'b0, id_s, g_s);
      n_cmp++;
      if (g_s !== order[i] || id_s !== i) begin
        n_err++;
        $display("FAIL rr_order: grant=%0d id=%0d want %0d/%0d", g_s, id_s, order[i], i);
      end
      if (i > 0) begin
        n_cmp++;
        if (g_cyc - prev !== 3) begin
          n_err++;
          $display("FAIL rr_spacing: got %0d cycles want 3", g_cyc - prev);
        end
      end
      prev = g_cyc;
    end
    valid = '0;
  endtask

  task automatic test_busy();
    int id_s, g_s;
    apply_reset();
    valid = 4'b0010;
    busy  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (ready !== '0 || req !== 1'b0) begin
        n_err++;
        $display("FAIL busy_block: ready=%b req=%b want 0/0", ready, req);
      end
      tick();
      m_stall++;
    end
    n_cmp++;
    if (stall !== 16'(m_stall)) begin
      n_err++;
      $display("FAIL stall_cnt: got %0d want %0d", stall, m_stall);
    end
    do_transfer(4'b0010, 2, 0, 1'b1, id_s, g_s);
    n_cmp++;
    if (g_s !== 1 || stall !== 16'(m_stall)) begin
      n_err++;
      $display("FAIL busy_release: grant=%0d stall=%0d want 1/%0d", g_s, stall, m_stall);
    end
    valid = '0;
  endtask

  task automatic test_four_phase();
    int id_s, g_s;
    do_transfer(4'b1000, 1, 5, 1'b0, id_s, g_s);
    do_transfer(4'b1000, 1, 0, 1'b0, id_s, g_s);
    valid = '0;
    ack   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (done !== '0 || st !== 2'd0) begin
        n_err++;
        $display("FAIL idle_ack: done=%b st=%0d want 0/0", done, st);
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_id_wrap();
    int id_s, g_s;
    apply_reset();
    for (int i = 0; i < 33; i++) begin
      tgt[0] = 16'($urandom_range(0, 65535));
      pay[0] = $urandom;
      do_transfer(4'b0001, $urandom_range(1, 3), $urandom_range(0, 2), 1'b0, id_s, g_s);
      if (i == 31 || i == 32) begin
        n_cmp++;
        if (id_s !== ((i == 31) ? 31 : 0)) begin
          n_err++;
          $display("FAIL id_wrap: flit %0d id=%0d want %0d", i + 1, id_s, (i == 31) ? 31 : 0);
        end
      end
    end
    valid = '0;
  endtask

  task automatic test_reset_mid();
    int id_s, g_s;
    valid = 4'b0100;
    #1;
    tick();
    n_cmp++;
    if (req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_req: req=%b want 1", req);
    end
    ack = 1'b1;
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    ack   = 1'b0;
    valid = '0;
    m_ptr = N - 1;
    m_id  = 0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (req !== 1'b0 || done !== '0 || flit !== '0 || st !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset: req=%b done=%b flit=%h st=%0d want 0/0/0/0", req, done, flit, st);
    end
    tick();
    n_cmp++;
    if (done !== '0) begin
      n_err++;
      $display("FAIL mid_nodone: done=%b want 0", done);
    end
    do_transfer(4'b1111, 1, 0, 1'b0, id_s, g_s);
    n_cmp++;
    if (g_s !== 0 || id_s !== 0) begin
      n_err++;
      $display("FAIL mid_restart: grant=%0d id=%0d want 0/0", g_s, id_s);
    end
    valid = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b1;
    valid    = '0;
    ack      = 1'b0;
    busy     = 1'b0;
    local_xy = 16'h0102;
    for (int r = 0; r < N; r++) begin
      tgt[r] = 16'($urandom_range(0, 65535));
      pay[r] = $urandom;
      svc[r] = 2'($urandom_range(0, 3));
    end
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_four_phase();
    test_id_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
